// File: rtl/up_down_counter_param_if.sv
// up_down_counter_param_if: control and status bundle of the parametrised up/down counter.
interface up_down_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 1
);
  logic              en;
  logic              up;
  logic              down;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clear;
  logic [WIDTH-1:0]  count;
  logic              at_zero;
  logic              at_max;
  logic              ovf;
  logic              unf;
  modport master (output en, up, down, step, load, load_val, clear,
                  input  count, at_zero, at_max, ovf, unf);
  modport slave  (input  en, up, down, step, load, load_val, clear,
                  output count, at_zero, at_max, ovf, unf);
endinterface

// File: rtl/up_down_counter_param.sv
// up_down_counter_param: width/modulus-generic up/down counter with variable step, load/clear,
// wrap or saturate mode, terminal flags and registered overflow/underflow pulses.
module up_down_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int STEP_W   = 1
) (
  input logic                   clk,
  input logic                   reset,
  up_down_counter_param_if.slave bus
);
  localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] LP_LIM = LP_MAX + 1'b1;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
  logic [WIDTH:0]   w_cnt, w_step, w_sum, w_up_val, w_dn_val, w_ld_val;
  logic             w_over, w_under, w_do_up, w_do_dn;
  // Everything is computed one bit wider than the count so a step past MAX_VAL is never truncated.
  assign w_cnt    = {1'b0, r_count};
  assign w_step   = {{(WIDTH+1-STEP_W){1'b0}}, bus.step};
  assign w_sum    = w_cnt + w_step;
  assign w_over   = w_sum > LP_MAX;
  assign w_under  = w_step > w_cnt;
  assign w_up_val = w_over ? (SATURATE != 0 ? LP_MAX : w_sum - LP_LIM) : w_sum;
  assign w_dn_val = w_under ? (SATURATE != 0 ? '0 : w_cnt + LP_LIM - w_step) : w_cnt - w_step;
  assign w_ld_val = {1'b0, bus.load_val} > LP_MAX ? LP_MAX : {1'b0, bus.load_val};
  assign w_do_up  = bus.en & bus.up & ~bus.down;
  assign w_do_dn  = bus.en & bus.down & ~bus.up;
  always_comb begin
    w_count_nxt = bus.clear ? '0 :
                  bus.load  ? w_ld_val[WIDTH-1:0] :
                  w_do_up   ? w_up_val[WIDTH-1:0] :
                  w_do_dn   ? w_dn_val[WIDTH-1:0] : r_count;
    w_ovf_nxt   = ~bus.clear & ~bus.load & w_do_up & w_over;
    w_unf_nxt   = ~bus.clear & ~bus.load & w_do_dn & w_under;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end
  assign bus.count   = r_count;
  assign bus.at_zero = r_count == '0;
  assign bus.at_max  = r_count == LP_MAX[WIDTH-1:0];
  assign bus.ovf     = r_ovf;
  assign bus.unf     = r_unf;
endmodule

// File: tb/tb_up_down_counter_param.sv
// tb_up_down_counter_param: three counter configurations driven by directed vectors; a monitor
// pops hand-computed expectations from a scoreboard queue one cycle after each vector is issued.
module tb_up_down_counter_param;
  typedef struct {int id; int cnt; bit ovf; bit unf;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   maxv [3] = '{7, 9, 5};
  exp_t q[$];
  always #5 clk = ~clk;
  up_down_counter_param_if #(.WIDTH(3), .STEP_W(1)) i0 ();
  up_down_counter_param_if #(.WIDTH(4), .STEP_W(2)) i1 ();
  up_down_counter_param_if #(.WIDTH(4), .STEP_W(2)) i2 ();
  up_down_counter_param #(.WIDTH(3), .MAX_VAL(7), .SATURATE(0), .STEP_W(1)) d0 (.clk(clk), .reset(reset), .bus(i0));
  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .STEP_W(2)) d1 (.clk(clk), .reset(reset), .bus(i1));
  up_down_counter_param #(.WIDTH(4), .MAX_VAL(5), .SATURATE(1), .STEP_W(2)) d2 (.clk(clk), .reset(reset), .bus(i2));

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic outs(input int id, output int c, output bit z, output bit m, output bit o, output bit u);
    case (id)
      0:       begin c = int'(i0.count); z = i0.at_zero; m = i0.at_max; o = i0.ovf; u = i0.unf; end
      1:       begin c = int'(i1.count); z = i1.at_zero; m = i1.at_max; o = i1.ovf; u = i1.unf; end
      default: begin c = int'(i2.count); z = i2.at_zero; m = i2.at_max; o = i2.ovf; u = i2.unf; end
    endcase
  endtask

  task automatic check_all(input string nm, input int id, input int c, input bit o, input bit u);
    int ac;
    bit az, am, ao, au;
    outs(id, ac, az, am, ao, au);
    chk({nm, ".count"}, ac, c);
    chk({nm, ".at_zero"}, int'(az), int'(c == 0));
    chk({nm, ".at_max"}, int'(am), int'(c == maxv[id]));
    chk({nm, ".ovf"}, int'(ao), int'(o));
    chk({nm, ".unf"}, int'(au), int'(u));
  endtask

  task automatic idle();
    {i0.en, i0.up, i0.down, i0.step, i0.load, i0.load_val, i0.clear} = '0;
    {i1.en, i1.up, i1.down, i1.step, i1.load, i1.load_val, i1.clear} = '0;
    {i2.en, i2.up, i2.down, i2.step, i2.load, i2.load_val, i2.clear} = '0;
  endtask

  task automatic drv(input int id, input bit e, input bit u, input bit d, input int st, input bit ld,
                     input int lv, input bit cl, input int ec, input bit eo, input bit eu);
    @(negedge clk);
    idle();
    case (id)
      0: begin i0.en = e; i0.up = u; i0.down = d; i0.step = 1'(st); i0.load = ld; i0.load_val = 3'(lv); i0.clear = cl; end
      1: begin i1.en = e; i1.up = u; i1.down = d; i1.step = 2'(st); i1.load = ld; i1.load_val = 4'(lv); i1.clear = cl; end
      default: begin i2.en = e; i2.up = u; i2.down = d; i2.step = 2'(st); i2.load = ld; i2.load_val = 4'(lv); i2.clear = cl; end
    endcase
    q.push_back('{id: id, cnt: ec, ovf: eo, unf: eu});
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_all($sformatf("dut%0d", e.id), e.id, e.cnt, e.ovf, e.unf);
    end
  end

  initial begin
    idle();
    #3;
    check_all("reset_async0", 0, 0, 0, 0);
    check_all("reset_async1", 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) drv(0, 1, 1, 0, 1, 0, 0, 0, i % 8, i == 8, 0);
    drv(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    drv(1, 1, 0, 1, 3, 0, 0, 0, 8, 0, 1);
    drv(1, 1, 0, 1, 3, 0, 0, 0, 5, 0, 0);
    drv(1, 1, 0, 1, 3, 0, 0, 0, 2, 0, 0);
    drv(1, 1, 1, 1, 1, 0, 0, 0, 2, 0, 0);
    drv(1, 1, 1, 0, 1, 1, 7, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 12, 0, 9, 0, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 0, 9, 0, 0);
    drv(1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    drv(1, 1, 0, 1, 1, 0, 0, 0, 9, 0, 1);
    drv(1, 0, 1, 0, 3, 0, 0, 0, 9, 0, 0);
    drv(2, 0, 0, 0, 0, 1, 4, 0, 4, 0, 0);
    drv(2, 1, 1, 0, 3, 0, 0, 0, 5, 1, 0);
    drv(2, 1, 1, 0, 3, 0, 0, 0, 5, 1, 0);
    drv(2, 1, 0, 1, 2, 0, 0, 0, 3, 0, 0);
    drv(2, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    drv(2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    drv(2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    drv(2, 1, 1, 0, 3, 0, 0, 0, 3, 0, 0);
    drv(2, 1, 1, 0, 2, 0, 0, 0, 5, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 8, 0, 8, 0, 0);
    drv(1, 1, 1, 0, 3, 0, 0, 0, 1, 1, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_all("midreset1", 1, 0, 0, 0);
    check_all("midreset2", 2, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("midreset_hold", 1, 0, 0, 0);
    reset = 1'b1;
    drv(1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    drv(1, 1, 1, 0, 2, 0, 0, 0, 3, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
